// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed common-anode seven-segment scanner.
// New values are committed only at frame boundaries, so a frame never shows
// a mix of old and new digits. Leading zeros can be blanked, and each digit
// has its own decimal point.
// Optional feature macro: SEVEN_SEG_BRIGHTNESS_EN adds the `bright` port and
// gates the active anode with a 4-bit PWM counter.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]              bright,
`endif
  output logic [NUM_DIGITS-1:0]   Anode_Activate,
  output logic [6:0]              LED_out,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_slotCnt;
  logic [IDX_W-1:0]        r_digitIdx;
  logic [4*NUM_DIGITS-1:0] r_pendVal;
  logic [NUM_DIGITS-1:0]   r_pendDp;
  logic                    r_pendFlag;
  logic [4*NUM_DIGITS-1:0] r_dispVal;
  logic [NUM_DIGITS-1:0]   r_dispDp;

  logic                    w_slotEnd;
  logic                    w_frameEnd;
  logic [3:0]              w_nibble;
  logic                    w_dpBit;
  logic                    w_blank;
  logic                    w_upperZero;
  logic [NUM_DIGITS-1:0]   w_anodeSel;
  logic                    w_pwmOn;

  // Active-low abcdefg font for one hex nibble.
  function automatic logic [6:0] hexFont(input logic [3:0] nib);
    case (nib)
      4'h0: hexFont = 7'b0000001;
      4'h1: hexFont = 7'b1001111;
      4'h2: hexFont = 7'b0010010;
      4'h3: hexFont = 7'b0000110;
      4'h4: hexFont = 7'b1001100;
      4'h5: hexFont = 7'b0100100;
      4'h6: hexFont = 7'b0100000;
      4'h7: hexFont = 7'b0001111;
      4'h8: hexFont = 7'b0000000;
      4'h9: hexFont = 7'b0000100;
      4'hA: hexFont = 7'b0001000;
      4'hB: hexFont = 7'b1100000;
      4'hC: hexFont = 7'b0110001;
      4'hD: hexFont = 7'b1000010;
      4'hE: hexFont = 7'b0110000;
      default: hexFont = 7'b0111000;
    endcase
  endfunction

  assign w_slotEnd  = (r_slotCnt == CNT_LAST);
  assign w_frameEnd = w_slotEnd && (r_digitIdx == IDX_LAST);

  // Slot counter and digit index: each digit owns PRESCALE cycles, then the scan moves on.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      r_slotCnt  <= '0;
      r_digitIdx <= '0;
    end else if (w_slotEnd) begin
      r_slotCnt  <= '0;
      r_digitIdx <= (r_digitIdx == IDX_LAST) ? '0 : r_digitIdx + IDX_W'(1);
    end else begin
      r_slotCnt  <= r_slotCnt + CNT_W'(1);
    end
  end

  // Pending/display double buffer; display only changes on the edge that closes a frame.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      r_pendVal  <= '0;
      r_pendDp   <= '0;
      r_pendFlag <= 1'b0;
      r_dispVal  <= '0;
      r_dispDp   <= '0;
    end else if (w_frameEnd) begin
      r_pendFlag <= 1'b0;
      if (load) begin
        r_pendVal <= value;
        r_pendDp  <= dp_in;
        r_dispVal <= value;
        r_dispDp  <= dp_in;
      end else if (r_pendFlag) begin
        r_dispVal <= r_pendVal;
        r_dispDp  <= r_pendDp;
      end
    end else if (load) begin
      r_pendVal  <= value;
      r_pendDp   <= dp_in;
      r_pendFlag <= 1'b1;
    end
  end

  // Select the current digit's nibble/dp and decide whether it is a blanked leading zero.
  always_comb begin
    w_nibble    = '0;
    w_dpBit     = 1'b0;
    w_blank     = 1'b0;
    w_upperZero = 1'b1;
    w_anodeSel  = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upperZero = w_upperZero && (r_dispVal[4*k +: 4] == 4'h0);
      if (r_digitIdx == IDX_W'(k)) begin
        w_nibble      = r_dispVal[4*k +: 4];
        w_dpBit       = r_dispDp[k];
        w_anodeSel[k] = 1'b0;
        w_blank       = blank_lz && (k != 0) && w_upperZero;
      end
    end
  end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0] r_pwmCnt;

  // Free-running PWM counter; the anode is enabled while it is at or below the duty setting.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) r_pwmCnt <= '0;
    else        r_pwmCnt <= r_pwmCnt + 4'd1;
  end

  assign w_pwmOn = (r_pwmCnt <= bright);
`else
  assign w_pwmOn = 1'b1;
`endif

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      Anode_Activate <= '1;
      LED_out        <= 7'h7F;
      dp_out         <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= (r_slotCnt == '0) && (r_digitIdx == '0);
      if (w_blank) begin
        Anode_Activate <= '1;
        LED_out        <= 7'h7F;
        dp_out         <= 1'b1;
      end else begin
        Anode_Activate <= w_pwmOn ? w_anodeSel : '1;
        LED_out        <= hexFont(w_nibble);
        dp_out         <= ~w_dpBit;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and randomized checks of the scan controller
// (4 digits, 4 cycles per digit) against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int FRAME = N * P;

  logic         clk;
  logic         rstN;
  logic         load;
  logic [15:0]  value;
  logic [3:0]   dpIn;
  logic         blankLz;
  logic [3:0]   anode;
  logic [6:0]   ledOut;
  logic         dpOut;
  logic         frameStart;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [15:0] mDispVal, mPendVal;
  logic [3:0]  mDispDp, mPendDp;
  bit          mPendFlag;

  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk_100mhz     (clk),
    .reset          (rstN),
    .load           (load),
    .value          (value),
    .dp_in          (dpIn),
    .blank_lz       (blankLz),
    .Anode_Activate (anode),
    .LED_out        (ledOut),
    .dp_out         (dpOut),
    .frame_start    (frameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, n, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] dp, input logic blz);
    load    = ld;
    value   = val;
    dpIn    = dp;
    blankLz = blz;
  endtask

  // One clock edge: predict the pins from the model, advance the model, compare.
  task automatic stepCycle();
    int          idx;
    logic [3:0]  nib;
    bit          blank;
    logic [3:0]  expAnode;
    logic [6:0]  expLed;
    logic        expDp;
    logic        expFs;
    @(posedge clk);
    n++;
    idx   = ((n - 1) / P) % N;
    expFs = ((n - 1) % FRAME) == 0;
    nib   = mDispVal[idx*4 +: 4];
    blank = blankLz && (idx != 0) && ((mDispVal >> (4 * idx)) == 16'h0);
    expAnode = blank ? 4'hF : ~(4'b0001 << idx);
    expLed   = blank ? 7'h7F : font[nib];
    expDp    = blank ? 1'b1 : ~mDispDp[idx];
    if ((n % FRAME) == 0) begin
      if (load) begin
        mDispVal = value; mDispDp = dpIn; mPendVal = value; mPendDp = dpIn;
      end else if (mPendFlag) begin
        mDispVal = mPendVal; mDispDp = mPendDp;
      end
      mPendFlag = 1'b0;
    end else if (load) begin
      mPendVal = value; mPendDp = dpIn; mPendFlag = 1'b1;
    end
    #1;
    checkOutput("anode", {4'h0, anode}, {4'h0, expAnode});
    checkOutput("led", {1'b0, ledOut}, {1'b0, expLed});
    checkOutput("dp", {7'h0, dpOut}, {7'h0, expDp});
    checkOutput("frame_start", {7'h0, frameStart}, {7'h0, expFs});
  endtask

  task automatic checkResetPins(input string tag);
    checkOutput({tag, "_anode"}, {4'h0, anode}, 8'h0F);
    checkOutput({tag, "_led"}, {1'b0, ledOut}, 8'h7F);
    checkOutput({tag, "_dp"}, {7'h0, dpOut}, 8'h01);
    checkOutput({tag, "_fs"}, {7'h0, frameStart}, 8'h00);
  endtask

  // Assert reset between edges, verify it acts immediately and holds, release mid-cycle.
  task automatic resetDut();
    #2 rstN = 1'b0;
    #1 checkResetPins("async_reset");
    @(posedge clk); #1 checkResetPins("held_reset");
    @(posedge clk); #1 checkResetPins("held_reset2");
    mDispVal = '0; mDispDp = '0; mPendVal = '0; mPendDp = '0; mPendFlag = 1'b0;
    n = 0;
    #2 rstN = 1'b1;
  endtask

  task automatic runUntilPhase(input int phase);
    for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) stepCycle();
  endtask

  task automatic runCycles(input int count);
    for (int i = 0; i < count; i++) stepCycle();
  endtask

  initial begin
    rstN = 1'b1;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    #1;
    resetDut();

    // Plain scan of zeros: anode walk and frame_start every FRAME cycles.
    runCycles(2 * FRAME);

    // Load in the middle of digit 1; must not show until the next frame.
    runUntilPhase(6);
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 1'b0); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    runCycles(2 * FRAME);

    // Leading-zero blanking.
    runUntilPhase(3);
    applyStimulus(1'b1, 16'h0070, 4'h0, 1'b1); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1);
    runCycles(2 * FRAME);
    applyStimulus(1'b1, 16'h0000, 4'hF, 1'b1); stepCycle();
    applyStimulus(1'b0, 16'hFFFF, 4'h0, 1'b1);
    runCycles(2 * FRAME);

    // Two loads in one frame, then a load coinciding with a frame boundary.
    runUntilPhase(2);
    applyStimulus(1'b1, 16'h1111, 4'h0, 1'b0); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0); runCycles(3);
    applyStimulus(1'b1, 16'h2222, 4'h0, 1'b0); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    runUntilPhase(15);
    stepCycle();
    runUntilPhase(15);
    applyStimulus(1'b1, 16'h3333, 4'h0, 1'b0); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    runCycles(FRAME + 3);

    // Decimal point on digit 2 only.
    applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0); stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    runCycles(2 * FRAME);

    // Reset in the middle of a slot, then resume.
    runUntilPhase(9);
    resetDut();
    runCycles(FRAME + 2);

    // Randomized loads, values, decimal points and blanking.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom),
                    4'($urandom), (i % 64) >= 32 ? 1'($urandom_range(0, 1)) : 1'b1);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
